lc3_mem_responder: RTL and testbench

Memory-side responder for the LC3 datapath: accepts a single-word access request (address from MAR, write-enable from the control unit's MEM_WE), services it against an internal 16-bit word array after a programmable number of wait states, and returns read data with a one-cycle ACK. It sits between the MAR/write-data registers and the MDR/IR load path. It also produces the STALL signal that holds the stage sequencer until the access completes.

---
 rtl/lc3_mem_responder_if.sv | 14 +
 rtl/lc3_mem_responder.sv | 78 +++++++
 tb/tb_lc3_mem_responder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/lc3_mem_responder_if.sv
// lc3_mem_responder_if: request/response bundle between the LC3 requester and the memory responder
interface lc3_mem_responder_if;
  logic        REQ;
  logic [15:0] MAR;
  logic        MEM_WE;
  logic [15:0] WDATA;
  logic [15:0] RDATA;
  logic        ACK;
  logic        BUSY;
  logic        STALL;
  logic        FAULT;
  modport master (output REQ, MAR, MEM_WE, WDATA, input RDATA, ACK, BUSY, STALL, FAULT);
  modport slave  (input REQ, MAR, MEM_WE, WDATA, output RDATA, ACK, BUSY, STALL, FAULT);
endinterface

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder: wait-stated 16-bit word memory with one-cycle ACK; `define MEM_FAULT_EN flags/suppresses out-of-range MAR
module lc3_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input logic              CLK,
  input logic              RST,
  lc3_mem_responder_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;
  state_t              state;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [15:0]         wdata_q;
  logic                bad_q;
  logic                fault_q;
  logic [15:0]         rdata;
  logic [15:0]         mem [0:(1<<ADDR_W)-1];
  logic                idle;
  logic                go;
  logic                bad_in;
  logic [ADDR_W-1:0]   a_idx;
  logic                a_we;
  logic [15:0]         a_wd;
  logic                a_bad;
`ifdef MEM_FAULT_EN
  assign bad_in = (bus.MAR >> ADDR_W) != 16'd0;
`else
  assign bad_in = 1'b0;
`endif
  // With zero wait states the access happens on the accept edge, so use live inputs in IDLE
  assign idle  = state == ST_IDLE;
  assign a_idx = idle ? bus.MAR[ADDR_W-1:0] : addr_q;
  assign a_we  = idle ? bus.MEM_WE : we_q;
  assign a_wd  = idle ? bus.WDATA : wdata_q;
  assign a_bad = idle ? bad_in : bad_q;
  assign go    = idle ? (bus.REQ && WAIT_CYCLES == 0) : (state == ST_WAIT && cnt == 4'd0);
  assign bus.RDATA = rdata;
  assign bus.ACK   = state == ST_DONE;
  assign bus.BUSY  = !idle;
  assign bus.FAULT = state == ST_DONE && fault_q;
  assign bus.STALL = bus.REQ && !bus.ACK;
  always_ff @(posedge CLK)
    if (!RST && go && a_we && !a_bad) mem[a_idx] <= a_wd;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      bad_q   <= 1'b0;
      fault_q <= 1'b0;
      rdata   <= '0;
    end else begin
      if (go) begin
        fault_q <= a_bad;
        if (!a_we) rdata <= a_bad ? 16'h0000 : mem[a_idx];
      end
      case (state)
        ST_IDLE: if (bus.REQ) begin
          addr_q  <= bus.MAR[ADDR_W-1:0];
          we_q    <= bus.MEM_WE;
          wdata_q <= bus.WDATA;
          bad_q   <= bad_in;
          state   <= WAIT_CYCLES == 0 ? ST_DONE : ST_WAIT;
          cnt     <= WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
        end
        ST_WAIT: begin
          state <= cnt == 4'd0 ? ST_DONE : ST_WAIT;
          cnt   <= cnt == 4'd0 ? cnt : cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb_lc3_mem_responder: directed scoreboard bench for the 2-wait and 0-wait responder builds
module tb_lc3_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  lc3_mem_responder_if b2();
  lc3_mem_responder_if b0();
  lc3_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut2 (.CLK(clk), .RST(rst), .bus(b2));
  lc3_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (.CLK(clk), .RST(rst), .bus(b0));
  typedef struct {
    logic        chk;
    logic [15:0] rd;
    logic        flt;
    int          cyc;
  } exp_t;
  exp_t q2[$];
  exp_t q0[$];
`ifdef MEM_FAULT_EN
  localparam logic [15:0] RD_ALIAS = 16'h5555;
  localparam logic [15:0] RD_HIGH  = 16'h0000;
  localparam logic        FLT      = 1'b1;
`else
  localparam logic [15:0] RD_ALIAS = 16'h7777;
  localparam logic [15:0] RD_HIGH  = 16'h7777;
  localparam logic        FLT      = 1'b0;
`endif
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic monitor(input string tag, input logic ack, input logic [15:0] rd, input logic flt,
                         inout exp_t q[$]);
    exp_t e;
    if (!ack) return;
    if (q.size() == 0) begin
      check({tag, "_unexpected_ack"}, 32'(ack), 32'd0);
      return;
    end
    e = q.pop_front();
    check({tag, "_ack_cycle"}, 32'(cyc), 32'(e.cyc));
    if (e.chk) check({tag, "_rdata"}, 32'(rd), 32'(e.rd));
    check({tag, "_fault"}, 32'(flt), 32'(e.flt));
  endtask
  always @(negedge clk) if (!rst) begin
    monitor("w2", b2.ACK, b2.RDATA, b2.FAULT, q2);
    monitor("w0", b0.ACK, b0.RDATA, b0.FAULT, q0);
  end
  task automatic wait_ack2(input logic drop);
    int n = 0;
    forever begin
      @(negedge clk);
      if (b2.ACK) break;
      check("w2_stall", 32'(b2.STALL), 32'd1);
      if (++n > 20) begin
        check("w2_ack_timeout", 32'd0, 32'd1);
        break;
      end
    end
    if (drop) b2.REQ = 1'b0;
  endtask
  task automatic acc2(input logic we, input logic [15:0] a, input logic [15:0] wd,
                      input logic [15:0] rd, input logic flt);
    @(negedge clk);
    b2.REQ = 1'b1; b2.MAR = a; b2.MEM_WE = we; b2.WDATA = wd;
    q2.push_back('{!we, rd, flt, cyc + 3});
    #1 check("w2_stall0", 32'(b2.STALL), 32'd1);
    wait_ack2(1'b1);
  endtask
  task automatic acc0(input logic we, input logic [15:0] a, input logic [15:0] wd, input logic [15:0] rd);
    int n = 0;
    @(negedge clk);
    b0.REQ = 1'b1; b0.MAR = a; b0.MEM_WE = we; b0.WDATA = wd;
    q0.push_back('{!we, rd, 1'b0, cyc + 1});
    forever begin
      @(negedge clk);
      if (b0.ACK) break;
      if (++n > 20) begin
        check("w0_ack_timeout", 32'd0, 32'd1);
        break;
      end
    end
    b0.REQ = 1'b0;
  endtask
  initial begin
    b0.REQ = 1'b0; b0.MAR = '0; b0.MEM_WE = 1'b0; b0.WDATA = '0;
    b2.REQ = 1'b1; b2.MAR = 16'h0005; b2.MEM_WE = 1'b1; b2.WDATA = 16'h5555;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_ack", 32'(b2.ACK), 32'd0);
    check("rst_busy", 32'(b2.BUSY), 32'd0);
    check("rst_rdata", 32'(b2.RDATA), 32'd0);
    check("rst_fault", 32'(b2.FAULT), 32'd0);
    q2.push_back('{1'b0, 16'h0, 1'b0, cyc + 3});
    @(negedge clk);
    check("rst_busy_after", 32'(b2.BUSY), 32'd1);
    wait_ack2(1'b1);
    acc2(1'b1, 16'h0012, 16'hBEEF, 16'h0, 1'b0);
    acc2(1'b0, 16'h0012, 16'h0000, 16'hBEEF, 1'b0);
    // held REQ: first access reads 0x12 from captured values, second writes 0x34
    @(negedge clk);
    b2.REQ = 1'b1; b2.MAR = 16'h0012; b2.MEM_WE = 1'b0; b2.WDATA = 16'h0000;
    q2.push_back('{1'b1, 16'hBEEF, 1'b0, cyc + 3});
    q2.push_back('{1'b0, 16'h0, 1'b0, cyc + 7});
    @(negedge clk);
    b2.MAR = 16'h0034; b2.MEM_WE = 1'b1; b2.WDATA = 16'h9999;
    wait_ack2(1'b0);
    wait_ack2(1'b1);
    acc2(1'b0, 16'h0034, 16'h0000, 16'h9999, 1'b0);
    acc2(1'b0, 16'h0012, 16'h0000, 16'hBEEF, 1'b0);
    @(negedge clk);
    b2.REQ = 1'b1; b2.MAR = 16'h0005; b2.MEM_WE = 1'b1; b2.WDATA = 16'hAAAA;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; b2.REQ = 1'b0;
    check("abort_busy", 32'(b2.BUSY), 32'd0);
    check("abort_rdata", 32'(b2.RDATA), 32'd0);
    repeat (5) @(negedge clk);
    acc2(1'b0, 16'h0005, 16'h0000, 16'h5555, 1'b0);
    acc2(1'b1, 16'h0105, 16'h7777, 16'h0, FLT);
    acc2(1'b0, 16'h0005, 16'h0000, RD_ALIAS, 1'b0);
    acc2(1'b0, 16'h0105, 16'h0000, RD_HIGH, FLT);
    check("fault_idle", 32'(b2.FAULT), 32'd0);
    acc0(1'b1, 16'h0000, 16'h1234, 16'h0);
    acc0(1'b0, 16'h0000, 16'h0000, 16'h1234);
    acc0(1'b1, 16'h0077, 16'hC0DE, 16'h0);
    acc0(1'b0, 16'h0077, 16'h0000, 16'hC0DE);
    repeat (3) @(negedge clk);
    check("w2_pending", 32'(q2.size()), 32'd0);
    check("w0_pending", 32'(q0.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
